typer_round_ctrl: RTL and testbench

Game-level sequencer for the speed-typer. It starts each round on the keyboard reader, loads each level's character sequence and timer, and interprets the reader's completion and timeout indications. It also tracks level, lives and score, and declares win or game-over. It sits between the board's start/abort controls and the reader/parser/timer datapath.

---
 rtl/typer_round_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_typer_round_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/typer_round_ctrl.sv
// -----------------------------------------------------------------------------
// typer_round_ctrl
// Game-level sequencer for the speed-typer. It starts each round on the
// keyboard reader and has the parser/timer load each level's character
// sequence and time limit. It reacts to the reader's completion and timeout
// indications, tracks level, lives and score, and declares win or game over.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   start        one-cycle pulse: begin a new game (IDLE, WIN, OVER only)
//   abort        level: return to IDLE on the next edge (highest priority)
//   round_done   pulse from reader: level typed correctly
//   round_fail   pulse from reader: level timer expired
//   level_load   one-cycle pulse: parser/timer load data for `level`
//   round_start  one-cycle pulse: reader arms and accepts keystrokes
//   level        current level index
//   lives        remaining lives
//   score        accumulated score (saturating)
//   busy         high while a round is in progress (LOAD..PAUSE)
//   game_won     held high in WIN
//   game_over    held high in OVER
//   state        state code for the HEX debug display
// -----------------------------------------------------------------------------
module typer_round_ctrl #(
  parameter int NUM_LEVELS   = 8,
  parameter int START_LIVES  = 3,
  parameter int RETRY_CYCLES = 50000000,
  parameter int PTS_BASE     = 10,
  parameter int LEVEL_W      = 4,
  parameter int SCORE_W      = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic               round_done,
  input  logic               round_fail,
  output logic               level_load,
  output logic               round_start,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               game_won,
  output logic               game_over,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_ARM   = 4'd2,
    ST_PLAY  = 4'd3,
    ST_SCORE = 4'd4,
    ST_FAIL  = 4'd5,
    ST_PAUSE = 4'd6,
    ST_WIN   = 4'd7,
    ST_OVER  = 4'd8
  } state_t;

  // Score arithmetic is done 8 bits wider than the score so the sum can be
  // compared against the saturation limit instead of wrapping.
  localparam int SUM_W = SCORE_W + 8;
  localparam int CNT_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

  localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [2:0]         INIT_LIVES  = 3'(START_LIVES);
  localparam logic [CNT_W-1:0]   RETRY_LOAD  = CNT_W'(RETRY_CYCLES - 1);
  localparam logic [SUM_W-1:0]   PTS_WIDE    = SUM_W'(PTS_BASE);
  localparam logic [SUM_W-1:0]   SCORE_LIMIT = {8'd0, {SCORE_W{1'b1}}};

  state_t             r_state;
  logic [LEVEL_W-1:0] r_level;
  logic [2:0]         r_lives;
  logic [SCORE_W-1:0] r_score;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_level_load;
  logic               r_round_start;
  logic               r_busy;
  logic               r_game_won;
  logic               r_game_over;

  state_t             w_next_state;
  logic [SUM_W-1:0]   w_level_wide;
  logic [SUM_W-1:0]   w_incr;
  logic [SUM_W-1:0]   w_sum;
  logic [SCORE_W-1:0] w_score_sat;

  // Points for the current level and the saturated new score.
  always_comb begin
    w_level_wide = SUM_W'(r_level);
    w_incr       = PTS_WIDE * (w_level_wide + SUM_W'(1));
    w_sum        = {8'd0, r_score} + w_incr;
    if (w_sum > SCORE_LIMIT) begin
      w_score_sat = {SCORE_W{1'b1}};
    end else begin
      w_score_sat = w_sum[SCORE_W-1:0];
    end
  end

  // Next-state decode; abort overrides every other input.
  always_comb begin
    w_next_state = r_state;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_WIN, ST_OVER: begin
          if (start) begin
            w_next_state = ST_LOAD;
          end else begin
            w_next_state = r_state;
          end
        end
        ST_LOAD:  w_next_state = ST_ARM;
        ST_ARM:   w_next_state = ST_PLAY;
        ST_PLAY: begin
          // A simultaneous done and fail counts as done.
          if (round_done) begin
            w_next_state = ST_SCORE;
          end else if (round_fail) begin
            w_next_state = ST_FAIL;
          end else begin
            w_next_state = ST_PLAY;
          end
        end
        ST_SCORE: begin
          if (r_level == LAST_LEVEL) begin
            w_next_state = ST_WIN;
          end else begin
            w_next_state = ST_LOAD;
          end
        end
        ST_FAIL: begin
          if (r_lives <= 3'd1) begin
            w_next_state = ST_OVER;
          end else begin
            w_next_state = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (r_cnt == '0) begin
            w_next_state = ST_LOAD;
          end else begin
            w_next_state = ST_PAUSE;
          end
        end
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  // State register, game counters and Moore outputs. The outputs are decoded
  // from the next state so that they line up with the state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_level       <= '0;
      r_lives       <= INIT_LIVES;
      r_score       <= '0;
      r_cnt         <= '0;
      r_level_load  <= 1'b0;
      r_round_start <= 1'b0;
      r_busy        <= 1'b0;
      r_game_won    <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_level_load  <= (w_next_state == ST_LOAD);
      r_round_start <= (w_next_state == ST_ARM);
      r_busy        <= (w_next_state == ST_LOAD)  || (w_next_state == ST_ARM)  ||
                       (w_next_state == ST_PLAY)  || (w_next_state == ST_SCORE) ||
                       (w_next_state == ST_FAIL)  || (w_next_state == ST_PAUSE);
      r_game_won    <= (w_next_state == ST_WIN);
      r_game_over   <= (w_next_state == ST_OVER);

      // abort leaves level/lives/score untouched; the next start clears them.
      if (!abort) begin
        case (r_state)
          ST_IDLE, ST_WIN, ST_OVER: begin
            if (start) begin
              r_level <= '0;
              r_lives <= INIT_LIVES;
              r_score <= '0;
            end
          end
          ST_SCORE: begin
            r_score <= w_score_sat;
            if (r_level != LAST_LEVEL) begin
              r_level <= r_level + LEVEL_W'(1);
            end
          end
          ST_FAIL: begin
            if (r_lives <= 3'd1) begin
              r_lives <= 3'd0;
            end else begin
              r_lives <= r_lives - 3'd1;
              r_cnt   <= RETRY_LOAD;
            end
          end
          ST_PAUSE: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign level_load  = r_level_load;
  assign round_start = r_round_start;
  assign level       = r_level;
  assign lives       = r_lives;
  assign score       = r_score;
  assign busy        = r_busy;
  assign game_won    = r_game_won;
  assign game_over   = r_game_over;
  assign state       = r_state;

endmodule

// File: tb/tb_typer_round_ctrl.sv
module tb_typer_round_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0, abort = 1'b0, round_done = 1'b0, round_fail = 1'b0;
  logic        level_load, round_start, busy, game_won, game_over;
  logic [3:0]  level, state;
  logic [2:0]  lives;
  logic [15:0] score;

  // Second instance for the saturation scenario (6-bit score, 40 points).
  logic        start2 = 1'b0, round_done2 = 1'b0;
  logic        level_load2, round_start2, busy2, game_won2, game_over2;
  logic [3:0]  level2, state2;
  logic [2:0]  lives2;
  logic [5:0]  score2;

  int errors = 0;
  int checks = 0;
  int ll_count = 0;
  int rs_count = 0;

  typedef struct {
    logic [3:0]  lvl;
    logic [2:0]  lv;
    logic [15:0] sc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  typer_round_ctrl #(.NUM_LEVELS(3), .START_LIVES(2), .RETRY_CYCLES(4),
                     .PTS_BASE(10), .LEVEL_W(4), .SCORE_W(16)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .round_done(round_done), .round_fail(round_fail),
    .level_load(level_load), .round_start(round_start), .level(level),
    .lives(lives), .score(score), .busy(busy), .game_won(game_won),
    .game_over(game_over), .state(state));

  typer_round_ctrl #(.NUM_LEVELS(3), .START_LIVES(2), .RETRY_CYCLES(4),
                     .PTS_BASE(40), .LEVEL_W(4), .SCORE_W(6)) dut_sat (
    .clk(clk), .resetn(resetn), .start(start2), .abort(1'b0),
    .round_done(round_done2), .round_fail(1'b0),
    .level_load(level_load2), .round_start(round_start2), .level(level2),
    .lives(lives2), .score(score2), .busy(busy2), .game_won(game_won2),
    .game_over(game_over2), .state(state2));

  // Scoreboard: every level_load must match the next expected entry.
  always @(negedge clk) begin
    if (resetn) begin
      if (round_start) rs_count++;
      if (level_load) begin
        exp_t e;
        ll_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_load: level=%0d got load, required none", level);
        end else begin
          e = exp_q.pop_front();
          if (level !== e.lvl || lives !== e.lv || score !== e.sc) begin
            errors++;
            $display("FAIL sb_load: lvl/lives/score=%0d/%0d/%0d required %0d/%0d/%0d",
                     level, lives, score, e.lvl, e.lv, e.sc);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input int l, input int lv, input int sc);
    exp_t e;
    e.lvl = 4'(l);
    e.lv  = 3'(lv);
    e.sc  = 16'(sc);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  // Start a game on dut and walk to PLAY, checking the pulse timing.
  task automatic start_game();
    push_exp(0, 2, 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    checks++;
    if (level_load !== 1'b1 || round_start !== 1'b0 || state !== 4'd1) begin
      errors++;
      $display("FAIL start_c1: ll=%0b rs=%0b st=%0d required 1 0 1", level_load, round_start, state);
    end
    cyc(1);
    checks++;
    if (level_load !== 1'b0 || round_start !== 1'b1 || state !== 4'd2) begin
      errors++;
      $display("FAIL start_c2: ll=%0b rs=%0b st=%0d required 0 1 2", level_load, round_start, state);
    end
    cyc(1);
    checks++;
    if (state !== 4'd3 || round_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_c3: st=%0d rs=%0b busy=%0b required 3 0 1", state, round_start, busy);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(3);
    checks++;
    if (state !== 4'd0 || level !== 4'd0 || lives !== 3'd2 || score !== 16'd0 ||
        level_load !== 1'b0 || round_start !== 1'b0 || busy !== 1'b0 ||
        game_won !== 1'b0 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: st=%0d lvl=%0d lives=%0d score=%0d", state, level, lives, score);
    end
    resetn = 1'b1;
    cyc(1);
    ll_count = 0;
    start_game();
    checks++;
    if (level !== 4'd0 || lives !== 3'd2 || score !== 16'd0) begin
      errors++;
      $display("FAIL play_init: lvl=%0d lives=%0d score=%0d required 0 2 0", level, lives, score);
    end
  endtask

  task automatic test_win();
    int exp_score = 0;
    for (int l = 0; l < 3; l++) begin
      exp_score += 10 * (l + 1);
      if (l < 2) push_exp(l + 1, 2, exp_score);
      round_done = 1'b1;
      cyc(1);
      round_done = 1'b0;
      chk("win_score_state", state, 4);
      cyc(1);
      chk("win_score_val", score, exp_score);
      chk("win_next_state", state, (l < 2) ? 1 : 7);
      if (l < 2) cyc(2);
    end
    cyc(3);
    chk("win_state_hold", state, 7);
    chk("win_game_won", game_won, 1);
    chk("win_level", level, 2);
    chk("win_busy", busy, 0);
    chk("win_load_count", ll_count, 3);
  endtask

  task automatic test_fail();
    int pause_cycles = 0;
    int ll_snap, rs_snap;
    start_game();
    push_exp(1, 2, 10);
    round_done = 1'b1; cyc(1); round_done = 1'b0;
    cyc(3);
    chk("fail_play_lvl1", state, 3);
    push_exp(1, 1, 10);
    round_fail = 1'b1; cyc(1); round_fail = 1'b0;
    chk("fail_state", state, 5);
    cyc(1);
    chk("fail_lives", lives, 1);
    while (state == 4'd6 && pause_cycles < 20) begin
      pause_cycles++;
      cyc(1);
    end
    chk("pause_len", pause_cycles, 4);
    chk("reload_state", state, 1);
    chk("reload_level", level, 1);
    cyc(1);
    chk("rearm_pulse", round_start, 1);
    cyc(1);
    round_fail = 1'b1; cyc(1); round_fail = 1'b0;
    cyc(1);
    chk("over_state", state, 8);
    chk("over_lives", lives, 0);
    chk("over_flag", game_over, 1);
    ll_snap = ll_count;
    rs_snap = rs_count;
    cyc(10);
    chk("over_no_load", ll_count, ll_snap);
    chk("over_no_rs", rs_count, rs_snap);
  endtask

  task automatic test_both();
    start_game();
    push_exp(1, 2, 10);
    round_done = 1'b1; round_fail = 1'b1;
    cyc(1);
    round_done = 1'b0; round_fail = 1'b0;
    chk("both_state", state, 4);
    cyc(1);
    chk("both_score", score, 10);
    chk("both_lives", lives, 2);
    cyc(2);
    chk("both_play", state, 3);
  endtask

  task automatic test_abort_reset();
    int ll_snap, rs_snap;
    // Currently in PLAY at level 1 with 2 lives.
    round_fail = 1'b1; cyc(1); round_fail = 1'b0;
    cyc(2);
    chk("abort_in_pause", state, 6);
    rs_snap = rs_count;
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("abort_state", state, 0);
    chk("abort_busy", busy, 0);
    cyc(8);
    chk("abort_no_rs", rs_count, rs_snap);
    chk("abort_stay_idle", state, 0);
    chk("abort_keeps_level", level, 1);
    chk("abort_keeps_lives", lives, 1);
    start_game();
    ll_snap = ll_count;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(3);
    chk("start_in_play_state", state, 3);
    chk("start_in_play_noload", ll_count, ll_snap);
    push_exp(1, 2, 10);
    round_done = 1'b1; cyc(1); round_done = 1'b0;
    cyc(3);
    chk("pre_reset_score", score, 10);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (state !== 4'd0 || level !== 4'd0 || lives !== 3'd2 || score !== 16'd0 ||
        busy !== 1'b0 || level_load !== 1'b0 || round_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: st=%0d lvl=%0d lives=%0d score=%0d busy=%0b",
               state, level, lives, score, busy);
    end
    cyc(2);
    resetn = 1'b1;
    cyc(1);
    start_game();
  endtask

  task automatic test_saturation();
    start2 = 1'b1; cyc(1); start2 = 1'b0;
    cyc(2);
    chk("sat_play", state2, 3);
    round_done2 = 1'b1; cyc(1); round_done2 = 1'b0;
    cyc(1);
    chk("sat_first", score2, 40);
    cyc(2);
    round_done2 = 1'b1; cyc(1); round_done2 = 1'b0;
    cyc(1);
    chk("sat_second", score2, 63);
    chk("sat_level", level2, 2);
  endtask

  initial begin
    test_reset();
    test_win();
    test_fail();
    test_both();
    test_abort_reset();
    test_saturation();
    cyc(2);
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
